perceptron_trainer: RTL

- Training (write-back) side of the perceptron branch predictor; the prediction datapath reads a weight row, this block updates it.
- Accepts one resolved-branch record from the EX/MEM stage: table index, actual outcome, predicted outcome, perceptron sum, and the history snapshot used at prediction time.
- Applies the perceptron learning rule with saturation via a read-modify-write of the weight table.
- Owns the global history register that feeds the prediction datapath.

---
 rtl/perceptron_pkg.sv | 39 +++
 rtl/perceptron_sat_step.sv | 23 ++
 rtl/perceptron_trainer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/perceptron_pkg.sv
// Shared definitions for the perceptron predictor training path:
// row layout defaults, training threshold, FSM states and row slice helpers.
package perceptron_pkg;

    localparam int unsigned HISTORY_DEF     = 8;
    localparam int unsigned WIDTH_WORD_DEF  = 8;
    localparam int unsigned BIAS_DEF        = 8;
    localparam int unsigned INDEX_WIDTH_DEF = 6;
    localparam int unsigned WEIGTH_DEF      = HISTORY_DEF * WIDTH_WORD_DEF + BIAS_DEF;
    localparam int unsigned SUM_WIDTH_DEF   = WIDTH_WORD_DEF + HISTORY_DEF + 1;

    // Training threshold floor(1.93*history + 14), kept in integer arithmetic.
    function automatic int unsigned theta_for(input int unsigned history);
        return (193 * history) / 100 + 14;
    endfunction

    localparam int unsigned THETA_DEF = theta_for(HISTORY_DEF);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CALC,
        WRITE,
        DONE
    } state_t;

    typedef logic [WEIGTH_DEF-1:0] row_t;

    // History weight i of a packed row (default geometry).
    function automatic logic [WIDTH_WORD_DEF-1:0] row_word(input row_t row, input int unsigned i);
        return row[WIDTH_WORD_DEF*i +: WIDTH_WORD_DEF];
    endfunction

    // Bias weight of a packed row (default geometry), held in the top bits.
    function automatic logic [BIAS_DEF-1:0] row_bias(input row_t row);
        return row[WEIGTH_DEF-1 -: BIAS_DEF];
    endfunction

endpackage

// File: rtl/perceptron_sat_step.sv
// Two's complement +1/-1 step that sticks at the most positive / most negative value.
module perceptron_sat_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    input  logic             inc,
    output logic [WIDTH-1:0] result
);

    localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    // Step toward the requested direction unless already at that bound.
    always_comb begin
        result = value;
        if (inc) begin
            if (value != MAX_VAL) result = value + WIDTH'(1);
        end else begin
            if (value != MIN_VAL) result = value - WIDTH'(1);
        end
    end

endmodule

// File: rtl/perceptron_trainer.sv
// Perceptron predictor training side: accepts resolved branches, keeps the
// global history, and read-modify-writes weight rows with the saturating
// perceptron learning rule when the prediction was wrong or weak.
module perceptron_trainer
    import perceptron_pkg::*;
#(
    parameter int unsigned HISTORY     = HISTORY_DEF,
    parameter int unsigned WIDTH_WORD  = WIDTH_WORD_DEF,
    parameter int unsigned BIAS        = BIAS_DEF,
    parameter int unsigned INDEX_WIDTH = INDEX_WIDTH_DEF,
    parameter int unsigned THETA       = theta_for(HISTORY),
    parameter int unsigned WEIGTH      = HISTORY * WIDTH_WORD + BIAS,
    parameter int unsigned SUM_WIDTH   = WIDTH_WORD + HISTORY + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   upd_valid,
    output logic                   upd_ready,
    input  logic [INDEX_WIDTH-1:0] upd_index,
    input  logic                   upd_taken,
    input  logic                   upd_predicted,
    input  logic [SUM_WIDTH-1:0]   upd_sum,
    input  logic [HISTORY-1:0]     upd_history,
    output logic                   tbl_rd_en,
    output logic [INDEX_WIDTH-1:0] tbl_rd_addr,
    input  logic [WEIGTH-1:0]      tbl_rd_data,
    output logic                   tbl_wr_en,
    output logic [INDEX_WIDTH-1:0] tbl_wr_addr,
    output logic [WEIGTH-1:0]      tbl_wr_data,
    output logic [HISTORY-1:0]     global_history_reg,
    output logic                   upd_done,
    output logic [15:0]            train_count,
    output logic [15:0]            mispredict_count
);

    state_t                 state, state_next;
    logic [INDEX_WIDTH-1:0] idx_q;
    logic                   taken_q;
    logic [HISTORY-1:0]     hist_q;
    logic [WEIGTH-1:0]      row_q;
    logic [WEIGTH-1:0]      row_calc;
    logic                   accept;
    logic                   mispredict;
    logic                   train;
    logic [SUM_WIDTH:0]     sum_ext;
    logic [SUM_WIDTH:0]     abs_sum;

    assign upd_ready  = (state == IDLE) || (state == DONE);
    assign accept     = upd_valid && upd_ready && !reset;
    assign mispredict = upd_taken != upd_predicted;

    // One extra bit so the most negative sum has a representable magnitude.
    assign sum_ext = {upd_sum[SUM_WIDTH-1], upd_sum};
    assign abs_sum = sum_ext[SUM_WIDTH] ? -sum_ext : sum_ext;
    assign train   = mispredict || (abs_sum <= (SUM_WIDTH+1)'(THETA));

    assign tbl_rd_addr = idx_q;
    assign tbl_wr_addr = idx_q;
    assign tbl_wr_data = row_q;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state and strobes; reset masks strobes in the same cycle so a pending write is dropped.
    always_comb begin
        state_next = state;
        tbl_rd_en  = 1'b0;
        tbl_wr_en  = 1'b0;
        upd_done   = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                upd_done = (state == DONE) && !reset;
                if (accept)             state_next = train ? READ : DONE;
                else if (state == DONE) state_next = IDLE;
            end
            READ: begin
                tbl_rd_en  = !reset;
                state_next = CALC;
            end
            CALC: state_next = WRITE;
            WRITE: begin
                tbl_wr_en  = !reset;
                upd_done   = !reset;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Record fields captured on accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q   <= '0;
            taken_q <= 1'b0;
            hist_q  <= '0;
        end else if (accept) begin
            idx_q   <= upd_index;
            taken_q <= upd_taken;
            hist_q  <= upd_history;
        end
    end

    // Global history shift and saturating mispredict counter, both on accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            global_history_reg <= '0;
            mispredict_count   <= '0;
        end else if (accept) begin
            global_history_reg <= {global_history_reg[HISTORY-2:0], upd_taken};
            if (mispredict && (mispredict_count != '1))
                mispredict_count <= mispredict_count + 16'd1;
        end
    end

    // Capture the updated row and count the training event in CALC.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_q       <= '0;
            train_count <= '0;
        end else if (state == CALC) begin
            row_q <= row_calc;
            if (train_count != '1) train_count <= train_count + 16'd1;
        end
    end

    // Per-word step: +1 when the outcome agrees with that history bit.
    for (genvar i = 0; i < HISTORY; i++) begin : g_word
        perceptron_sat_step #(.WIDTH(WIDTH_WORD)) u_step (
            .value  (tbl_rd_data[WIDTH_WORD*i +: WIDTH_WORD]),
            .inc    (taken_q ~^ hist_q[i]),
            .result (row_calc[WIDTH_WORD*i +: WIDTH_WORD])
        );
    end

    perceptron_sat_step #(.WIDTH(BIAS)) u_bias_step (
        .value  (tbl_rd_data[WEIGTH-1 -: BIAS]),
        .inc    (taken_q),
        .result (row_calc[WEIGTH-1 -: BIAS])
    );

endmodule
